// File: rtl/alu_arbiter_if.sv
// Bus bundle between the ALU arbiter and its two requesters, the ALU and the response consumer.
//  req0_* / req1_* : valid/ready request channels carrying op_a, op_b, ctrl and set_flags
//  alu_*           : operands and opcode to the ALU, result and NZCV back from it
//  rsp_*           : response channel (valid/ready) with id, result and err
//  nzcv            : architectural flag register
// The slave modport is the arbiter side; master is the requester/ALU/consumer side.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_op_a;
  logic [WIDTH-1:0] req0_op_b;
  logic [3:0]       req0_ctrl;
  logic             req0_set_flags;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_op_a;
  logic [WIDTH-1:0] req1_op_b;
  logic [3:0]       req1_ctrl;
  logic             req1_set_flags;

  logic [WIDTH-1:0] alu_op_a;
  logic [WIDTH-1:0] alu_op_b;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_nzcv;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;
  logic [3:0]       nzcv;

  modport slave (
    input  req0_valid, req0_op_a, req0_op_b, req0_ctrl, req0_set_flags,
    output req0_ready,
    input  req1_valid, req1_op_a, req1_op_b, req1_ctrl, req1_set_flags,
    output req1_ready,
    output alu_op_a, alu_op_b, alu_ctrl,
    input  alu_result, alu_nzcv,
    output rsp_valid, rsp_id, rsp_result, rsp_err,
    input  rsp_ready,
    output nzcv
  );

  modport master (
    output req0_valid, req0_op_a, req0_op_b, req0_ctrl, req0_set_flags,
    input  req0_ready,
    output req1_valid, req1_op_a, req1_op_b, req1_ctrl, req1_set_flags,
    input  req1_ready,
    input  alu_op_a, alu_op_b, alu_ctrl,
    output alu_result, alu_nzcv,
    input  rsp_valid, rsp_id, rsp_result, rsp_err,
    output rsp_ready,
    input  nzcv
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one execute-stage ALU between two requesters (0: execute pipe, 1: address/aux unit).
// An accepted request is latched, driven to the ALU for one cycle, and its result, error flag
// and requester id are returned on a backpressured response channel. Owns the NZCV register.
//  clk, rst_n : clock (rising edge), asynchronous active-low reset
//  bus        : alu_arbiter_if slave modport (request, ALU and response channels, nzcv)
// Parameters: WIDTH operand width; RR_ENABLE 1 = round-robin, 0 = req0 fixed priority.
module alu_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          RR_ENABLE = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             pick1_c, ready0_c, ready1_c, hs_c, illegal_c;
  logic [WIDTH-1:0] alu_op_a_q, alu_op_b_q, rsp_result_q;
  logic [3:0]       alu_ctrl_q, nzcv_q;
  logic             set_flags_q, id_q, last_grant_q;
  logic             rsp_valid_q, rsp_id_q, rsp_err_q;

  // Opcodes with no ALU function: 5, 6, 11-15
  always_comb begin
    illegal_c = 1'b0;
    case (alu_ctrl_q)
      4'd5, 4'd6, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: illegal_c = 1'b1;
      default: illegal_c = 1'b0;
    endcase
  end

  // Arbitration and next state; a contest goes to the requester that did not win last time
  always_comb begin
    state_d  = state_q;
    pick1_c  = 1'b0;
    ready0_c = 1'b0;
    ready1_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) pick1_c = RR_ENABLE && !last_grant_q;
    else                                  pick1_c = bus.req1_valid;
    case (state_q)
      IDLE: begin
        ready0_c = bus.req0_valid && !pick1_c;
        ready1_c = bus.req1_valid && pick1_c;
        if (ready0_c || ready1_c) state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hs_c = ready0_c || ready1_c;

  // State register; ALU drive registers double as the latched request copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_op_a_q   <= '0;
      alu_op_b_q   <= '0;
      alu_ctrl_q   <= '0;
      set_flags_q  <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      nzcv_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= (state_d == RESP);
      case (state_q)
        IDLE: begin
          if (hs_c) begin
            alu_op_a_q   <= pick1_c ? bus.req1_op_a : bus.req0_op_a;
            alu_op_b_q   <= pick1_c ? bus.req1_op_b : bus.req0_op_b;
            alu_ctrl_q   <= pick1_c ? bus.req1_ctrl : bus.req0_ctrl;
            set_flags_q  <= pick1_c ? bus.req1_set_flags : bus.req0_set_flags;
            id_q         <= pick1_c;
            last_grant_q <= pick1_c;
          end
        end
        EXEC: begin
          alu_op_a_q   <= '0;
          alu_op_b_q   <= '0;
          alu_ctrl_q   <= '0;
          rsp_result_q <= bus.alu_result;
          rsp_id_q     <= id_q;
          rsp_err_q    <= illegal_c;
          if (set_flags_q && !illegal_c) nzcv_q <= bus.alu_nzcv;
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = ready0_c;
  assign bus.req1_ready = ready1_c;
  assign bus.alu_op_a   = alu_op_a_q;
  assign bus.alu_op_b   = alu_op_b_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.nzcv       = nzcv_q;

endmodule
